// File: rtl/ecall_pkg.sv
// Shared definitions for the ecall service unit: service codes and FSM state encoding.
package ecall_pkg;

  localparam logic [7:0] ECALL_PRINT_INT = 8'd1;
  localparam logic [7:0] ECALL_READ_INT  = 8'd5;
  localparam logic [7:0] ECALL_EXIT      = 8'd10;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRel,
    StWaitPress,
    StDone,
    StHalt
  } ecall_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer, stable-level debounce counter,
// debounced level and a registered one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            toggle;

  // Counter only runs while the synchronized level disagrees with the debounced one,
  // so any bounce back to the current level restarts the stability window.
  assign toggle = (sync2_q != level) && (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      rise    <= toggle && sync2_q;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (toggle) begin
        cnt_q <= '0;
        level <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/ecall_unit.sv
// Services ecall instructions: stalls the PC, runs PRINT/READ/EXIT against board I/O
// and returns READ results for register a0.
module ecall_unit
  import ecall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ecall_req,
  input  logic [31:0]         pc,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                confirm_btn,
  output logic                ecall_busy,
  output logic                wb_en,
  output logic [31:0]         wb_data,
  output logic [31:0]         seg_value,
  output logic                halted
);

  ecall_state_e state_q;
  logic         armed_q;
  logic [31:0]  pc_q;
  logic [7:0]   code_q;
  logic         armed;
  logic         start;
  logic         btn_level;
  logic         btn_rise;
  logic         unused_a7_hi;

  assign unused_a7_hi = ^a7[31:8];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock(clock),
    .reset(reset),
    .btn  (confirm_btn),
    .level(btn_level),
    .rise (btn_rise)
  );

  // A new pc re-arms immediately so back-to-back ecalls stall from their first cycle.
  assign armed = armed_q || (pc != pc_q);
  assign start = (state_q == StIdle) && ecall_req && armed;

  assign ecall_busy = start || (state_q == StWaitRel) || (state_q == StWaitPress) ||
                      (state_q == StHalt);
  assign halted     = (state_q == StHalt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      armed_q   <= 1'b1;
      pc_q      <= '0;
      code_q    <= '0;
      wb_en     <= 1'b0;
      wb_data   <= '0;
      seg_value <= '0;
    end else begin
      wb_en <= 1'b0;
      if (!ecall_req || (pc != pc_q)) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            armed_q <= 1'b0;
            pc_q    <= pc;
            code_q  <= a7[7:0];
            case (a7[7:0])
              ECALL_PRINT_INT: begin
                seg_value <= a0;
                state_q   <= StWaitRel;
              end
              ECALL_READ_INT: state_q <= StWaitRel;
              ECALL_EXIT:     state_q <= StHalt;
              default:        state_q <= StDone;
            endcase
          end
        end
        // A press already in progress at entry must be released before it can count.
        StWaitRel: begin
          if (!btn_level) begin
            state_q <= StWaitPress;
          end
        end
        StWaitPress: begin
          if (btn_rise) begin
            state_q <= StDone;
            if (code_q == ECALL_READ_INT) begin
              wb_en   <= 1'b1;
              wb_data <= 32'(sw);
            end
          end
        end
        StDone:  state_q <= StIdle;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_unit.sv
// Directed bench for ecall_unit with a write-back scoreboard checked by a separate monitor.
module tb_ecall_unit;

  localparam int unsigned SwW = 16;

  logic           clock;
  logic           reset;
  logic           ecall_req;
  logic [31:0]    pc;
  logic [31:0]    a7;
  logic [31:0]    a0;
  logic [SwW-1:0] sw;
  logic           confirm_btn;
  logic           ecall_busy;
  logic           wb_en;
  logic [31:0]    wb_data;
  logic [31:0]    seg_value;
  logic           halted;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  ecall_unit #(
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH       (SwW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ecall_req  (ecall_req),
    .pc         (pc),
    .a7         (a7),
    .a0         (a0),
    .sw         (sw),
    .confirm_btn(confirm_btn),
    .ecall_busy (ecall_busy),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .seg_value  (seg_value),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: every write-back strobe must match the oldest expected READ result.
  always @(negedge clock) begin
    if (!reset && wb_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wb: got wb_data 0x%08h, expected no write-back", wb_data);
      end else begin
        check_word("scoreboard_wb_data", wb_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] code, input logic [31:0] arg, input logic [31:0] addr);
    a7        = code;
    a0        = arg;
    pc        = addr;
    ecall_req = 1'b1;
    #1;
  endtask

  // Hold the button for 'hold' cycles; report the cycle on which busy first dropped.
  task automatic press(input int hold, input int max_cycles, output int done_at,
                       output logic wb_seen, output logic [31:0] data_seen);
    done_at   = 0;
    wb_seen   = 1'b0;
    data_seen = '0;
    confirm_btn = 1'b1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clock);
      if (i == hold) confirm_btn = 1'b0;
      if (done_at == 0 && !ecall_busy) begin
        done_at   = i;
        wb_seen   = wb_en;
        data_seen = wb_data;
        ecall_req = 1'b0;
      end
      if (done_at != 0 && i >= hold) break;
    end
    confirm_btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          done_at;
    logic        wb_seen;
    logic [31:0] data_seen;

    reset = 1'b1; ecall_req = 1'b0; pc = '0; a7 = '0; a0 = '0; sw = '0; confirm_btn = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check_bit ("reset_busy",      ecall_busy, 1'b0);
    check_bit ("reset_wb_en",     wb_en,      1'b0);
    check_word("reset_wb_data",   wb_data,    32'h0);
    check_word("reset_seg_value", seg_value,  32'h0);
    check_bit ("reset_halted",    halted,     1'b0);

    // PRINT
    @(negedge clock);
    issue(32'd1, 32'h0000_1234, 32'h100);
    check_bit("print_busy_same_cycle", ecall_busy, 1'b1);
    @(negedge clock);
    check_word("print_seg_value", seg_value, 32'h0000_1234);
    repeat (10) @(negedge clock);
    check_bit("print_waits_for_press", ecall_busy, 1'b1);
    press(10, 40, done_at, wb_seen, data_seen);
    check_word("print_press_latency", 32'(done_at), 32'd7);
    check_bit ("print_no_wb_in_done", wb_seen, 1'b0);
    repeat (12) @(negedge clock);

    // READ with the button already held at the ecall
    confirm_btn = 1'b1;
    repeat (10) @(negedge clock);
    sw = 16'h1234;
    issue(32'd5, 32'h0, 32'h200);
    exp_q.push_back(32'h0000_BEEF);
    check_bit("read_busy_same_cycle", ecall_busy, 1'b1);
    repeat (20) @(negedge clock);
    check_bit("read_held_btn_blocks", ecall_busy, 1'b1);
    confirm_btn = 1'b0;
    repeat (10) @(negedge clock);
    check_bit("read_release_alone_blocks", ecall_busy, 1'b1);
    sw = 16'hBEEF;
    press(7, 40, done_at, wb_seen, data_seen);
    check_word("read_press_latency", 32'(done_at), 32'd7);
    check_bit ("read_wb_en_in_done", wb_seen, 1'b1);
    check_word("read_wb_data_in_done", data_seen, 32'h0000_BEEF);
    sw = 16'h5555;
    @(negedge clock);
    check_bit("read_wb_single_pulse", wb_en, 1'b0);
    repeat (12) @(negedge clock);

    // Bounce rejection in WAIT_PRESS
    issue(32'd1, 32'h0000_CAFE, 32'h300);
    repeat (4) @(negedge clock);
    for (int g = 1; g <= 3; g++) begin
      confirm_btn = 1'b1;
      repeat (g) @(negedge clock);
      confirm_btn = 1'b0;
      repeat (8) @(negedge clock);
      check_bit("bounce_glitch_ignored", ecall_busy, 1'b1);
    end
    press(6, 40, done_at, wb_seen, data_seen);
    check_word("bounce_stable_press_latency", 32'(done_at), 32'd7);
    check_word("bounce_seg_value", seg_value, 32'h0000_CAFE);
    repeat (12) @(negedge clock);

    // Back-to-back no-op ecalls with ecall_req held high
    issue(32'd3, 32'h0, 32'h10);
    check_bit("b2b_first_busy", ecall_busy, 1'b1);
    @(negedge clock);
    check_bit("b2b_first_done", ecall_busy, 1'b0);
    @(negedge clock);
    #1;
    check_bit("b2b_stale_no_retrigger", ecall_busy, 1'b0);
    pc = 32'h14;
    #1;
    check_bit("b2b_second_busy", ecall_busy, 1'b1);
    @(negedge clock);
    check_bit("b2b_second_done", ecall_busy, 1'b0);
    ecall_req = 1'b0;
    pc = 32'h18;
    check_word("noop_keeps_seg", seg_value, 32'h0000_CAFE);
    repeat (3) @(negedge clock);

    // Reset while waiting for a press abandons the READ
    issue(32'd5, 32'h0, 32'h400);
    repeat (4) @(negedge clock);
    confirm_btn = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    ecall_req = 1'b0;
    #1;
    check_bit ("midreset_busy_drops", ecall_busy, 1'b0);
    check_word("midreset_seg_cleared", seg_value, 32'h0);
    confirm_btn = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (20) @(negedge clock);
    check_bit("midreset_stays_idle", ecall_busy, 1'b0);

    // EXIT is absorbing
    issue(32'd10, 32'h0, 32'h500);
    check_bit("exit_busy_same_cycle", ecall_busy, 1'b1);
    @(negedge clock);
    check_bit("exit_halted", halted, 1'b1);
    ecall_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      confirm_btn = (i % 2 == 0);
      repeat (10) @(negedge clock);
    end
    confirm_btn = 1'b0;
    check_bit("exit_still_halted", halted, 1'b1);
    check_bit("exit_still_busy", ecall_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_bit("exit_reset_clears_halted", halted, 1'b0);
    check_bit("exit_reset_clears_busy", ecall_busy, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);

    // Unknown code completes in two cycles
    issue(32'd3, 32'h0, 32'h600);
    check_bit("unknown_busy_cycle1", ecall_busy, 1'b1);
    @(negedge clock);
    check_bit("unknown_done_cycle2", ecall_busy, 1'b0);
    ecall_req = 1'b0;
    repeat (3) @(negedge clock);
    check_word("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
